debounce_bank: RTL



---
 rtl/debounce_bank.sv | 74 +++++++
 1 files changed

// File: rtl/debounce_bank.sv
// debounce_bank: per-channel sync, shared-tick sampling and N-sample agreement debounce
// driving a clean level plus one-cycle rise, fall and long-press pulses.
module debounce_bank #(
  parameter int N_CH = 4,
  parameter int TICK_CYCLES = 1250000,
  parameter int SAMPLES = 3,
  parameter int HOLD_TICKS = 80,
  parameter logic [N_CH-1:0] INVERT = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_CH-1:0] inp,
  output logic [N_CH-1:0] level,
  output logic [N_CH-1:0] rise,
  output logic [N_CH-1:0] fall,
  output logic [N_CH-1:0] held,
  output logic            tick
);
  localparam int CW = $clog2(TICK_CYCLES);
  localparam int HW = $clog2(HOLD_TICKS + 1);
  logic [N_CH-1:0] r_s1, r_s2, w_x;
  logic [CW-1:0] r_cnt;
  assign tick = r_cnt == CW'(TICK_CYCLES - 1);
  assign w_x = r_s2 ^ INVERT;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      r_s1  <= '0;
      r_s2  <= '0;
      r_cnt <= '0;
    end else begin
      r_s1  <= inp;
      r_s2  <= r_s1;
      r_cnt <= tick ? '0 : r_cnt + CW'(1);
    end
  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    logic [SAMPLES-1:0] r_hist, w_h;
    logic [HW-1:0] r_hcnt;
    logic r_level, r_rise, r_fall, r_held;
    assign w_h = {r_hist[SAMPLES-2:0], w_x[i]};
    // hcnt only advances while high and saturates, so held fires once per press
    always_ff @(posedge clk or negedge rst)
      if (!rst) begin
        r_hist  <= '0;
        r_hcnt  <= '0;
        r_level <= 1'b0;
        r_rise  <= 1'b0;
        r_fall  <= 1'b0;
        r_held  <= 1'b0;
      end else begin
        r_rise <= 1'b0;
        r_fall <= 1'b0;
        r_held <= 1'b0;
        if (tick) begin
          r_hist <= w_h;
          if (&w_h && !r_level) begin
            r_level <= 1'b1;
            r_rise  <= 1'b1;
            r_hcnt  <= '0;
          end else if (~|w_h && r_level) begin
            r_level <= 1'b0;
            r_fall  <= 1'b1;
            r_hcnt  <= '0;
          end else if (r_level && r_hcnt < HW'(HOLD_TICKS)) begin
            r_hcnt <= r_hcnt + HW'(1);
            r_held <= r_hcnt == HW'(HOLD_TICKS - 1);
          end
        end
      end
    assign level[i] = r_level;
    assign rise[i]  = r_rise;
    assign fall[i]  = r_fall;
    assign held[i]  = r_held;
  end
endmodule
